// File: rtl/sparse_stream_pkg.sv
// Shared token encoding and state type for the sparse stream primitives.
// Control tokens carry bit 16 set; stops encode their level in the low nibble.
package sparse_stream_pkg;

  localparam int TOKEN_W  = 17;
  localparam int CTRL_BIT = 16;

  localparam logic [TOKEN_W-1:0] STOP_BASE  = 17'h10000;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_STOP,
    ST_DONE_TOK
  } stream_src_state_t;

  function automatic logic [TOKEN_W-1:0] mk_stop(input logic [3:0] lvl);
    return STOP_BASE | {{(TOKEN_W-4){1'b0}}, lvl};
  endfunction

endpackage

// File: rtl/stream_src_counters.sv
// Captured configuration plus fiber/element counters and the value accumulator.
// The counters always describe the token currently presented on the output.
module stream_src_counters #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              load,
  input  logic              step_elem,
  input  logic              next_fiber,
  input  logic [CNT_W-1:0]  cfg_num_fibers,
  input  logic [CNT_W-1:0]  cfg_fiber_len,
  input  logic [DATA_W-1:0] cfg_start_value,
  input  logic [DATA_W-1:0] cfg_stride,
  output logic [DATA_W-1:0] acc,
  output logic              last_elem,
  output logic              last_fiber,
  output logic              len_zero
);

  logic [CNT_W-1:0]  num_fibers;
  logic [CNT_W-1:0]  fiber_len;
  logic [DATA_W-1:0] start_value;
  logic [DATA_W-1:0] stride;
  logic [CNT_W-1:0]  fiber_idx;
  logic [CNT_W-1:0]  elem_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      num_fibers  <= '0;
      fiber_len   <= '0;
      start_value <= '0;
      stride      <= '0;
      fiber_idx   <= '0;
      elem_idx    <= '0;
      acc         <= '0;
    end else if (clk_en) begin
      if (load) begin
        num_fibers  <= cfg_num_fibers;
        fiber_len   <= cfg_fiber_len;
        start_value <= cfg_start_value;
        stride      <= cfg_stride;
        fiber_idx   <= '0;
        elem_idx    <= '0;
        acc         <= cfg_start_value;
      end else if (step_elem) begin
        elem_idx <= elem_idx + CNT_W'(1);
        acc      <= acc + stride;
      end else if (next_fiber) begin
        fiber_idx <= fiber_idx + CNT_W'(1);
        elem_idx  <= '0;
        acc       <= start_value;
      end
    end
  end

  // Flags are only consulted in states where the corresponding length is nonzero.
  assign last_elem  = (elem_idx == fiber_len - CNT_W'(1));
  assign last_fiber = (fiber_idx == num_fibers - CNT_W'(1));
  assign len_zero   = (fiber_len == '0);

endmodule

// File: rtl/sparse_stream_source.sv
// Configuration-driven sparse stream generator: fibers of strided values, stop
// tokens between fibers and a final DONE, on a ready/valid output.
module sparse_stream_source
  import sparse_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_fibers,
  input  logic [CNT_W-1:0]  cfg_fiber_len,
  input  logic [DATA_W-1:0] cfg_start_value,
  input  logic [DATA_W-1:0] cfg_stride,
  input  logic [3:0]        cfg_stop_lvl,
  output logic [DATA_W:0]   data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              busy,
  output logic              done_pulse,
  output logic [31:0]       tx_count
);

  stream_src_state_t state, state_n;
  logic              rst_any;
  logic              fire;
  logic              load, step_elem, next_fiber, done_n;
  logic [3:0]        stop_lvl;
  logic [DATA_W-1:0] acc;
  logic              last_elem, last_fiber, len_zero;
  logic [TOKEN_W-1:0] tok;

  assign rst_any = rst | flush;
  assign fire    = data_out_valid & data_out_ready;

  stream_src_counters #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_counters (
    .clk             (clk),
    .rst             (rst_any),
    .clk_en          (clk_en),
    .load            (load),
    .step_elem       (step_elem),
    .next_fiber      (next_fiber),
    .cfg_num_fibers  (cfg_num_fibers),
    .cfg_fiber_len   (cfg_fiber_len),
    .cfg_start_value (cfg_start_value),
    .cfg_stride      (cfg_stride),
    .acc             (acc),
    .last_elem       (last_elem),
    .last_fiber      (last_fiber),
    .len_zero        (len_zero)
  );

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state      <= ST_IDLE;
      done_pulse <= 1'b0;
      tx_count   <= '0;
      stop_lvl   <= '0;
    end else if (clk_en) begin
      state      <= state_n;
      done_pulse <= done_n;
      if (load) begin
        tx_count <= '0;
        stop_lvl <= cfg_stop_lvl;
      end else if (fire && tx_count != '1) begin
        tx_count <= tx_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    step_elem  = 1'b0;
    next_fiber = 1'b0;
    done_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && tile_en) begin
          load = 1'b1;
          if (cfg_num_fibers == '0)     state_n = ST_DONE_TOK;
          else if (cfg_fiber_len == '0) state_n = ST_STOP;
          else                          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fire) begin
          step_elem = 1'b1;
          if (last_elem) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fire) begin
          if (last_fiber) begin
            state_n = ST_DONE_TOK;
          end else begin
            next_fiber = 1'b1;
            state_n    = len_zero ? ST_STOP : ST_DATA;
          end
        end
      end
      ST_DONE_TOK: begin
        if (fire) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Token decoded purely from registered state, so it cannot change until a transfer.
  always_comb begin
    tok = '0;
    case (state)
      ST_DATA: begin
        tok           = TOKEN_W'(acc);
        tok[CTRL_BIT] = 1'b0;
      end
      ST_STOP:     tok = mk_stop(last_fiber ? stop_lvl + 4'd1 : stop_lvl);
      ST_DONE_TOK: tok = DONE_TOKEN;
      default:     tok = '0;
    endcase
  end

  assign data_out       = tok;
  assign data_out_valid = (state != ST_IDLE);
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_sparse_stream_source.sv
// Directed bench for sparse_stream_source: a token scoreboard fed from a
// nested-loop model, popped by a monitor that also checks stall stability.
module tb_sparse_stream_source;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, tile_en, start;
  logic [15:0] cfg_num_fibers, cfg_fiber_len, cfg_start_value, cfg_stride;
  logic [3:0]  cfg_stop_lvl;
  logic [16:0] data_out;
  logic        data_out_valid;
  wire         data_out_ready;
  logic        busy, done_pulse;
  logic [31:0] tx_count;

  logic        ready_level = 1'b1;
  logic        rand_ready  = 1'b0;
  logic        rnd_bit     = 1'b1;
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          cyc_start;
  logic [16:0] sb[$];
  logic [16:0] hold_data;
  logic        hold_pending = 1'b0;
  logic [16:0] exp_tok;

  sparse_stream_source dut (
    .clk             (clk),
    .rst             (rst),
    .clk_en          (clk_en),
    .flush           (flush),
    .tile_en         (tile_en),
    .start           (start),
    .cfg_num_fibers  (cfg_num_fibers),
    .cfg_fiber_len   (cfg_fiber_len),
    .cfg_start_value (cfg_start_value),
    .cfg_stride      (cfg_stride),
    .cfg_stop_lvl    (cfg_stop_lvl),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .data_out_ready  (data_out_ready),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .tx_count        (tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  assign data_out_ready = rand_ready ? rnd_bit : ready_level;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream built directly from the tensor shape.
  task automatic pushExpected(input int nf, input int len, input logic [15:0] sv,
                              input logic [15:0] stride, input logic [3:0] lvl);
    logic [15:0] v;
    logic [3:0]  lvl_last;
    lvl_last = lvl + 4'd1;
    for (int f = 0; f < nf; f++) begin
      v = sv;
      for (int e = 0; e < len; e++) begin
        sb.push_back({1'b0, v});
        v = v + stride;
      end
      if (f == nf - 1) sb.push_back({13'h1000, lvl_last});
      else             sb.push_back({13'h1000, lvl});
    end
    sb.push_back(17'h10100);
  endtask

  task automatic applyStimulus(input int nf, input int len, input logic [15:0] sv,
                               input logic [15:0] stride, input logic [3:0] lvl,
                               input bit expect_run);
    cfg_num_fibers  = 16'(nf);
    cfg_fiber_len   = 16'(len);
    cfg_start_value = sv;
    cfg_stride      = stride;
    cfg_stop_lvl    = lvl;
    if (expect_run) pushExpected(nf, len, sv, stride, lvl);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  // Transfers are judged at the negedge before the edge that completes them.
  always @(negedge clk) begin
    if (rst || flush) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("valid_hold", {31'd0, data_out_valid}, 32'd1);
        checkOutput("data_hold", {15'd0, data_out}, {15'd0, hold_data});
      end
      if (data_out_valid && data_out_ready && clk_en) begin
        hold_pending = 1'b0;
        if (sb.size() == 0) begin
          n_total++;
          $error("[TB] FAIL extra_token: observed %0h expected none", data_out);
        end else begin
          exp_tok = sb.pop_front();
          checkOutput("token", {15'd0, data_out}, {15'd0, exp_tok});
        end
      end else if (data_out_valid) begin
        hold_pending = 1'b1;
        hold_data    = data_out;
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1; start = 1'b0;
    cfg_num_fibers = '0; cfg_fiber_len = '0; cfg_start_value = '0;
    cfg_stride = '0; cfg_stop_lvl = '0;
    tick(); tick(); tick();
    checkOutput("rst_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("rst_data", {15'd0, data_out}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done_pulse}, 32'd0);
    checkOutput("rst_tx", tx_count, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic stream, ready high");
    cyc_start = cyc;
    applyStimulus(2, 3, 16'd1, 16'd2, 4'd0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_pulse) break;
    end
    checkOutput("done_latency", 32'(cyc - cyc_start), 32'd10);
    checkOutput("tx_basic", tx_count, 32'd9);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    checkOutput("sb_basic", 32'(sb.size()), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done_pulse}, 32'd0);
    tick();

    $display("[TB] random backpressure, start while busy, clock-enable freeze");
    rand_ready = 1'b1;
    applyStimulus(2, 3, 16'd1, 16'd2, 4'd0, 1'b1);
    repeat (6) tick();
    applyStimulus(5, 5, 16'h1234, 16'd7, 4'd9, 1'b0);
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    waitIdle("backpressure");
    rand_ready = 1'b0;
    checkOutput("tx_backpressure", tx_count, 32'd9);
    repeat (3) tick();
    checkOutput("busy_start_ignored", {31'd0, busy}, 32'd0);

    $display("[TB] degenerate sizes");
    applyStimulus(0, 3, 16'd5, 16'd1, 4'd0, 1'b1);
    waitIdle("zero_fibers");
    checkOutput("tx_zero_fibers", tx_count, 32'd1);
    applyStimulus(3, 0, 16'd5, 16'd1, 4'd0, 1'b1);
    waitIdle("zero_len");
    checkOutput("tx_zero_len", tx_count, 32'd4);

    $display("[TB] wrap-around of values and stop level");
    applyStimulus(1, 3, 16'hFFFE, 16'd3, 4'd15, 1'b1);
    waitIdle("wrap");
    checkOutput("tx_wrap", tx_count, 32'd5);

    $display("[TB] tile disabled");
    tile_en = 1'b0;
    applyStimulus(2, 2, 16'd1, 16'd1, 4'd0, 1'b0);
    repeat (4) tick();
    checkOutput("tile_off_busy", {31'd0, busy}, 32'd0);
    checkOutput("tile_off_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("tile_off_tx", tx_count, 32'd5);
    tile_en = 1'b1;

    $display("[TB] flush mid-fiber then restart");
    applyStimulus(2, 3, 16'd1, 16'd2, 4'd0, 1'b1);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    checkOutput("flush_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_tx", tx_count, 32'd0);
    applyStimulus(1, 2, 16'd7, 16'd1, 4'd3, 1'b1);
    waitIdle("after_flush");
    checkOutput("tx_after_flush", tx_count, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
